// File: rtl/otter_fetch_pkg.sv
// rtl/otter_fetch_pkg.sv - shared types and constants for the OTTER fetch stage
//
// Contents:
//   fetch_entry_t   {pc, instr} pair held in the fetch FIFO and presented to decode
//   OTTER_RESET_VEC default byte address fetched first after reset
//   INSTR_NOP       canonical RV32I nop (addi x0,x0,0)
//   word_align()    clears the byte-offset bits of a byte address
package otter_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] OTTER_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP       = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/otter_fetch_if.sv
// rtl/otter_fetch_if.sv - fetch-stage bus: BRAM instruction port plus decode handshake
//
// Signals:
//   MEM_RDEN1       fetch -> memory  read enable
//   MEM_ADDR1       fetch -> memory  word address (ADDR_W bits)
//   MEM_DOUT1       memory -> fetch  instruction word, one cycle after a read edge
//   IF_REDIRECT     core -> fetch    flush and refetch from IF_REDIRECT_PC
//   IF_REDIRECT_PC  core -> fetch    redirect target byte address
//   IF_VALID        fetch -> decode  IF_PC/IF_INSTR hold a valid instruction
//   IF_READY        decode -> fetch  decode accepts this cycle
//   IF_PC           fetch -> decode  byte address of presented instruction
//   IF_INSTR        fetch -> decode  presented instruction word
//   IF_MISALIGN     fetch -> core    one-cycle pulse for a misaligned redirect target
// Modports: master = fetch unit, slave = memory/decode/core side.
interface otter_fetch_if #(
    parameter int ADDR_W = 14
);
    logic              MEM_RDEN1;
    logic [ADDR_W-1:0] MEM_ADDR1;
    logic [31:0]       MEM_DOUT1;
    logic              IF_REDIRECT;
    logic [31:0]       IF_REDIRECT_PC;
    logic              IF_VALID;
    logic              IF_READY;
    logic [31:0]       IF_PC;
    logic [31:0]       IF_INSTR;
    logic              IF_MISALIGN;

    modport master (
        output MEM_RDEN1,
        output MEM_ADDR1,
        input  MEM_DOUT1,
        input  IF_REDIRECT,
        input  IF_REDIRECT_PC,
        output IF_VALID,
        input  IF_READY,
        output IF_PC,
        output IF_INSTR,
        output IF_MISALIGN
    );

    modport slave (
        input  MEM_RDEN1,
        input  MEM_ADDR1,
        output MEM_DOUT1,
        output IF_REDIRECT,
        output IF_REDIRECT_PC,
        input  IF_VALID,
        output IF_READY,
        input  IF_PC,
        input  IF_INSTR,
        input  IF_MISALIGN
    );

endinterface

// File: rtl/otter_fetch_fifo.sv
// rtl/otter_fetch_fifo.sv - 2-entry {pc,instr} FIFO with flush, head held in a register
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   push   in   write din at this edge
//   din    in   entry to write
//   pop    in   drop the head at this edge (caller guarantees !empty)
//   flush  in   discard all entries; dominates push and pop
//   occ    out  number of stored entries (0..2)
//   empty  out  occ == 0
//   head   out  oldest entry, straight from a register
module otter_fetch_fifo
    import otter_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   occ,
    output logic         empty,
    output fetch_entry_t head
);

    // Shift-style storage: slot0 is always the head so the decode-facing
    // outputs come directly from flops with no read mux.
    fetch_entry_t slot0;
    fetch_entry_t slot1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        slot0 <= din;
                    end else begin
                        slot1 <= din;
                    end
                    if (occ != 2'd2) begin
                        occ <= occ + 2'd1;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new entry lands behind whatever
                    // survives the pop so order is preserved.
                    if (occ == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end else begin
                        slot0 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign empty = (occ == 2'd0);
    assign head  = slot0;

    overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && (occ == 2'd2)));

endmodule

// File: rtl/otter_fetch_unit.sv
// rtl/otter_fetch_unit.sv - OTTER instruction fetch: PC, BRAM read port, redirect, decode handshake
//
// Ports:
//   CLK    in   system clock, all state on the rising edge
//   RST_N  in   asynchronous active-low reset
//   bus    otter_fetch_if.master
//            MEM_RDEN1/MEM_ADDR1/MEM_DOUT1   synchronous BRAM read port (1-cycle latency)
//            IF_REDIRECT/IF_REDIRECT_PC      flush and refetch from a new target
//            IF_VALID/IF_READY/IF_PC/IF_INSTR instruction handoff to decode
//            IF_MISALIGN                     pulse the cycle after a misaligned redirect
// Parameters:
//   RESET_VEC  byte address fetched first after reset
//   ADDR_W     width of the word address driven on MEM_ADDR1 (PC[ADDR_W+1:2])
module otter_fetch_unit
    import otter_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = OTTER_RESET_VEC,
    parameter int          ADDR_W    = 14
) (
    input logic           CLK,
    input logic           RST_N,
    otter_fetch_if.master bus
);

    logic [31:0]  fetch_pc;
    logic         inflight;
    logic [31:0]  inflight_pc;
    logic         misalign_q;

    logic [1:0]   occ;
    logic         empty;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    logic         pop;
    logic         push;
    logic         issue;
    logic         rden;
    logic [2:0]   level;
    logic [31:0]  tgt;
    logic [ADDR_W-1:0] addr;

    assign pop = !empty && bus.IF_READY;
    assign tgt = word_align(bus.IF_REDIRECT_PC);

    // Entries already owned by this stage: stored plus the one coming back
    // from memory. A new request is allowed only if it still fits in the
    // FIFO after this cycle's pop, so the FIFO can never overflow.
    assign level = {1'b0, occ} + {2'b00, inflight};
    assign issue = level < (3'd2 + {2'b00, pop});

    always_comb begin
        rden = issue;
        addr = fetch_pc[ADDR_W+1:2];
        if (bus.IF_REDIRECT) begin
            rden = 1'b1;
            addr = bus.IF_REDIRECT_PC[ADDR_W+1:2];
        end
    end

    // Reset must silence the memory port immediately, not at the next edge.
    assign bus.MEM_RDEN1 = rden && RST_N;
    assign bus.MEM_ADDR1 = addr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_pc    <= RESET_VEC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_VEC;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= bus.IF_REDIRECT && (bus.IF_REDIRECT_PC[1:0] != 2'b00);
            if (bus.IF_REDIRECT) begin
                fetch_pc    <= tgt + 32'd4;
                inflight    <= 1'b1;
                inflight_pc <= tgt;
            end else if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
            end else begin
                inflight <= 1'b0;
            end
        end
    end

    // A response returning in a redirect cycle belongs to the old path and
    // is dropped; the flush clears everything already buffered.
    assign push       = inflight && !bus.IF_REDIRECT;
    assign push_entry = '{pc: inflight_pc, instr: bus.MEM_DOUT1};

    otter_fetch_fifo u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .flush (bus.IF_REDIRECT),
        .occ   (occ),
        .empty (empty),
        .head  (head)
    );

    assign bus.IF_VALID    = !empty;
    assign bus.IF_PC       = head.pc;
    assign bus.IF_INSTR    = head.instr;
    assign bus.IF_MISALIGN = misalign_q;

endmodule

// File: tb/tb_otter_fetch_unit.sv
// tb/tb_otter_fetch_unit.sv - self-checking bench for otter_fetch_unit
module tb_otter_fetch_unit;

    logic clk;
    logic rst_n;
    logic [31:0] mem_dout = 32'h0;

    otter_fetch_if #(.ADDR_W(14)) bus ();

    otter_fetch_unit #(.RESET_VEC(32'h0000_0000), .ADDR_W(14)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 1-cycle synchronous BRAM, word[i] = A000_0000 + i, output holds when not read
    always @(posedge clk) begin
        if (bus.MEM_RDEN1) mem_dout <= 32'hA000_0000 + {18'd0, bus.MEM_ADDR1};
    end
    assign bus.MEM_DOUT1 = mem_dout;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %08h want %08h", name, act, exp);
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'hA000_0000 + {18'd0, pc[15:2]};
    endfunction

    // Reference model: the stream decode should see is just "start address,
    // then +4 each", restarted by reset or redirect.
    logic [31:0] exp_pc, fetch_exp, prev_pc, prev_instr, prev_tgt;
    logic        prev_valid, prev_ready, prev_redirect;
    int          pending, age;

    task automatic model_reset();
        exp_pc        = 32'h0;
        fetch_exp     = 32'h0;
        pending       = 0;
        age           = 0;
        prev_valid    = 1'b0;
        prev_ready    = 1'b0;
        prev_redirect = 1'b0;
        prev_tgt      = 32'h0;
        prev_pc       = 32'h0;
        prev_instr    = 32'h0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Called at the negedge: check the cycle against the model, advance the
    // model, then move to just after the next rising edge.
    task automatic tick();
        logic pop;
        logic [31:0] tgt;
        if (!rst_n) begin
            model_reset();
        end else begin
            pop = bus.IF_VALID && bus.IF_READY;
            tgt = {bus.IF_REDIRECT_PC[31:2], 2'b00};
            if (pop) begin
                check("pop_pc", bus.IF_PC, exp_pc);
                check("pop_instr", bus.IF_INSTR, word_of(exp_pc));
            end
            if (age >= 2) check("valid_stream", {31'd0, bus.IF_VALID}, 32'd1);
            else if (age == 1) check("valid_bubble", {31'd0, bus.IF_VALID}, 32'd0);
            check("misalign", {31'd0, bus.IF_MISALIGN},
                  {31'd0, prev_redirect && (prev_tgt[1:0] != 2'b00)});
            if (prev_valid && !prev_ready && !prev_redirect) begin
                check("stall_valid", {31'd0, bus.IF_VALID}, 32'd1);
                check("stall_pc", bus.IF_PC, prev_pc);
                check("stall_instr", bus.IF_INSTR, prev_instr);
            end
            if (bus.IF_REDIRECT) begin
                check("redir_rden", {31'd0, bus.MEM_RDEN1}, 32'd1);
                check("redir_addr", {18'd0, bus.MEM_ADDR1}, {18'd0, tgt[15:2]});
            end else if (bus.MEM_RDEN1) begin
                check("fetch_addr", {18'd0, bus.MEM_ADDR1}, {18'd0, fetch_exp[15:2]});
            end
            prev_valid    = bus.IF_VALID;
            prev_ready    = bus.IF_READY;
            prev_pc       = bus.IF_PC;
            prev_instr    = bus.IF_INSTR;
            prev_redirect = bus.IF_REDIRECT;
            prev_tgt      = bus.IF_REDIRECT_PC;
            if (pop) exp_pc = exp_pc + 32'd4;
            if (bus.IF_REDIRECT) begin
                exp_pc    = tgt;
                fetch_exp = tgt + 32'd4;
                pending   = 1;
                age       = 1;
            end else begin
                if (bus.MEM_RDEN1) begin
                    fetch_exp = fetch_exp + 32'd4;
                    pending++;
                end
                if (pop) pending--;
                if (age < 1000) age++;
            end
            check("pending_bound", 32'(pending <= 2 && pending >= 0), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_outputs_check(input string tag);
        check({tag, "_valid"}, {31'd0, bus.IF_VALID}, 32'd0);
        check({tag, "_rden"}, {31'd0, bus.MEM_RDEN1}, 32'd0);
        check({tag, "_pc"}, bus.IF_PC, 32'd0);
        check({tag, "_instr"}, bus.IF_INSTR, 32'd0);
        check({tag, "_misalign"}, {31'd0, bus.IF_MISALIGN}, 32'd0);
        check({tag, "_addr"}, {18'd0, bus.MEM_ADDR1}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] addr;
        logic        mis;
        logic [31:0] pc0;
        logic [31:0] in0;
        logic [31:0] pc1;
        logic [31:0] in1;
    } redir_vec_t;

    redir_vec_t vecs [6];

    initial begin
        vecs[0] = '{32'h0000_0040, 32'h0010, 1'b0, 32'h0000_0040, 32'hA000_0010, 32'h0000_0044, 32'hA000_0011};
        vecs[1] = '{32'h0000_0042, 32'h0010, 1'b1, 32'h0000_0040, 32'hA000_0010, 32'h0000_0044, 32'hA000_0011};
        vecs[2] = '{32'h0000_FFFC, 32'h3FFF, 1'b0, 32'h0000_FFFC, 32'hA000_3FFF, 32'h0001_0000, 32'hA000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 32'h3FFF, 1'b1, 32'hFFFF_FFFC, 32'hA000_3FFF, 32'h0000_0000, 32'hA000_0000};
        vecs[4] = '{32'h1234_5679, 32'h159E, 1'b1, 32'h1234_5678, 32'hA000_159E, 32'h1234_567C, 32'hA000_159F};
        vecs[5] = '{32'h0000_0100, 32'h0040, 1'b0, 32'h0000_0100, 32'hA000_0040, 32'h0000_0104, 32'hA000_0041};

        rst_n              = 1'b1;
        bus.IF_READY       = 1'b1;
        bus.IF_REDIRECT    = 1'b0;
        bus.IF_REDIRECT_PC = 32'h0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 reset_outputs_check("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Stream from reset, then a 5-cycle stall with the head at 0x10
        for (int k = 0; k < 14; k++) begin
            bus.IF_READY = !(k >= 6 && k <= 10);
            settle();
            if (k == 0) begin
                check("first_rden", {31'd0, bus.MEM_RDEN1}, 32'd1);
                check("first_addr", {18'd0, bus.MEM_ADDR1}, 32'd0);
                check("first_valid", {31'd0, bus.IF_VALID}, 32'd0);
            end
            if (k == 1) check("lat_valid", {31'd0, bus.IF_VALID}, 32'd0);
            if (k >= 2 && k <= 5) begin
                check("stream_pc", bus.IF_PC, 32'(4 * (k - 2)));
                check("stream_instr", bus.IF_INSTR, 32'hA000_0000 + 32'(k - 2));
            end
            if (k >= 6 && k <= 10) check("hold_pc", bus.IF_PC, 32'h10);
            if (k >= 8 && k <= 10) check("full_rden", {31'd0, bus.MEM_RDEN1}, 32'd0);
            if (k >= 11) check("resume_pc", bus.IF_PC, 32'h10 + 32'(4 * (k - 11)));
            tick();
        end

        // Redirect to 0x40 while stalled with a full FIFO
        bus.IF_READY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            tick();
        end
        bus.IF_REDIRECT    = 1'b1;
        bus.IF_REDIRECT_PC = 32'h40;
        settle();
        check("full_redir_addr", {18'd0, bus.MEM_ADDR1}, 32'h10);
        tick();
        bus.IF_REDIRECT = 1'b0;
        settle();
        check("full_redir_bubble", {31'd0, bus.IF_VALID}, 32'd0);
        tick();
        settle();
        check("full_redir_pc", bus.IF_PC, 32'h40);
        check("full_redir_instr", bus.IF_INSTR, 32'hA000_0010);
        tick();
        bus.IF_READY = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            tick();
        end

        // Table of redirect targets, including misaligned and wrapping ones
        for (int i = 0; i < 6; i++) begin
            bus.IF_REDIRECT    = 1'b1;
            bus.IF_REDIRECT_PC = vecs[i].tgt;
            settle();
            check("tbl_addr", {18'd0, bus.MEM_ADDR1}, vecs[i].addr);
            tick();
            bus.IF_REDIRECT = 1'b0;
            settle();
            check("tbl_bubble", {31'd0, bus.IF_VALID}, 32'd0);
            check("tbl_misalign", {31'd0, bus.IF_MISALIGN}, {31'd0, vecs[i].mis});
            tick();
            settle();
            check("tbl_pc0", bus.IF_PC, vecs[i].pc0);
            check("tbl_in0", bus.IF_INSTR, vecs[i].in0);
            check("tbl_mis_once", {31'd0, bus.IF_MISALIGN}, 32'd0);
            tick();
            settle();
            check("tbl_pc1", bus.IF_PC, vecs[i].pc1);
            check("tbl_in1", bus.IF_INSTR, vecs[i].in1);
            tick();
        end

        // Back-to-back redirects: the later one wins
        bus.IF_REDIRECT    = 1'b1;
        bus.IF_REDIRECT_PC = 32'h80;
        settle();
        tick();
        bus.IF_REDIRECT_PC = 32'hC0;
        settle();
        check("b2b_valid0", {31'd0, bus.IF_VALID}, 32'd0);
        tick();
        bus.IF_REDIRECT = 1'b0;
        settle();
        check("b2b_valid1", {31'd0, bus.IF_VALID}, 32'd0);
        tick();
        settle();
        check("b2b_pc", bus.IF_PC, 32'hC0);
        check("b2b_instr", bus.IF_INSTR, 32'hA000_0030);
        tick();

        // Reset during a full-FIFO stall
        bus.IF_READY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            tick();
        end
        rst_n = 1'b0;
        #1 reset_outputs_check("midreset");
        settle();
        tick();
        settle();
        tick();
        rst_n        = 1'b1;
        bus.IF_READY = 1'b1;
        settle();
        check("restart_rden", {31'd0, bus.MEM_RDEN1}, 32'd1);
        check("restart_addr", {18'd0, bus.MEM_ADDR1}, 32'd0);
        tick();
        settle();
        tick();
        settle();
        check("restart_pc", bus.IF_PC, 32'h0);
        check("restart_instr", bus.IF_INSTR, 32'hA000_0000);
        tick();

        // Random ready/redirect traffic against the model
        for (int k = 0; k < 800; k++) begin
            bus.IF_READY = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 5) begin
                bus.IF_REDIRECT    = 1'b1;
                bus.IF_REDIRECT_PC = $urandom;
            end else begin
                bus.IF_REDIRECT = 1'b0;
            end
            settle();
            tick();
        end
        bus.IF_REDIRECT = 1'b0;
        bus.IF_READY    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
